serial_mag_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator. Successor to the team's 4-bit combinational lt/eq/gt comparator.
- Compares two WIDTH-bit operands DIGIT bits per clock, MSB digit first, with a start/busy/done handshake.
- Supports a runtime unsigned/signed (two's complement) mode and optional early termination at the first differing digit.
- Sits in datapaths where a full-width combinational compare would not meet timing, or where area must be traded for latency.

---
 rtl/serial_mag_comparator.sv | 194 +++++++++++++++++++
 tb/tb_serial_mag_comparator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// serial_mag_comparator
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are captured when
// a compare is accepted, then compared DIGIT bits per clock, most significant
// digit first. A runtime mode selects an unsigned or a two's complement
// compare. With EARLY_EXIT = 1 the compare stops at the first differing
// digit; with EARLY_EXIT = 0 it always takes NDIG digit-cycles.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   start        in   request a compare (accepted only in IDLE)
//   mode_signed  in   0 = unsigned, 1 = two's complement (sampled at accept)
//   op_a, op_b   in   operands (sampled at accept)
//   busy         out  high while digits are being compared
//   done         out  one-cycle pulse, results valid from this cycle on
//   lt, eq, gt   out  A < B, A == B, A > B (one-hot after done)
//   cycles       out  digit-cycles used by the last compare
// ---------------------------------------------------------------------------
module serial_mag_comparator #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int NDIG      = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1,
  localparam int CW        = $clog2(NDIG) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [CW-1:0]    cycles
);

  // Reject parameter sets that cannot be split into whole digits.
  generate
    if ((DIGIT < 1) ? 1'b1 : ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("serial_mag_comparator: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, w_a_next, w_b_next;
  logic [IW-1:0]    r_idx, w_idx_next;
  logic             r_lt, r_eq, r_gt;
  logic             w_lt_next, w_eq_next, w_gt_next;
  logic [CW-1:0]    r_cycles, w_cycles_next;
  // Sticky "first difference" record used when running the full length.
  logic             r_dec, r_dec_lt, r_dec_gt;
  logic             w_dec_next, w_dec_lt_next, w_dec_gt_next;

  logic [WIDTH-1:0] w_sign_mask;
  logic [DIGIT-1:0] w_dig_a [NDIG];
  logic [DIGIT-1:0] w_dig_b [NDIG];
  logic [DIGIT-1:0] w_cur_a, w_cur_b;
  logic             w_cur_lt, w_cur_gt, w_last;
  logic             w_fin_lt, w_fin_gt;
  logic [CW-1:0]    w_cnt;

  // Digit gi is slice [WIDTH-1-DIGIT*gi -: DIGIT]; digit 0 is the MSB digit.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digits
      assign w_dig_a[gi] = r_a[WIDTH-1-DIGIT*gi -: DIGIT];
      assign w_dig_b[gi] = r_b[WIDTH-1-DIGIT*gi -: DIGIT];
    end
  endgenerate

  // Flipping the sign bit of both operands maps two's complement ordering
  // onto unsigned ordering, so the digit engine itself is always unsigned.
  assign w_sign_mask = WIDTH'(mode_signed) << (WIDTH - 1);

  assign w_cur_a  = w_dig_a[r_idx];
  assign w_cur_b  = w_dig_b[r_idx];
  assign w_cur_lt = (w_cur_a < w_cur_b);
  assign w_cur_gt = (w_cur_a > w_cur_b);
  assign w_last   = (r_idx == IW'(NDIG - 1));
  assign w_cnt    = CW'(r_idx) + CW'(1);

  // An earlier recorded difference always outranks the current digit.
  assign w_fin_lt = r_dec ? r_dec_lt : w_cur_lt;
  assign w_fin_gt = r_dec ? r_dec_gt : w_cur_gt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_cycles <= '0;
      r_dec    <= 1'b0;
      r_dec_lt <= 1'b0;
      r_dec_gt <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_a      <= w_a_next;
      r_b      <= w_b_next;
      r_idx    <= w_idx_next;
      r_lt     <= w_lt_next;
      r_eq     <= w_eq_next;
      r_gt     <= w_gt_next;
      r_cycles <= w_cycles_next;
      r_dec    <= w_dec_next;
      r_dec_lt <= w_dec_lt_next;
      r_dec_gt <= w_dec_gt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_a_next      = r_a;
    w_b_next      = r_b;
    w_idx_next    = r_idx;
    w_lt_next     = r_lt;
    w_eq_next     = r_eq;
    w_gt_next     = r_gt;
    w_cycles_next = r_cycles;
    w_dec_next    = r_dec;
    w_dec_lt_next = r_dec_lt;
    w_dec_gt_next = r_dec_gt;
    busy          = 1'b0;
    done          = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next  = S_RUN;
          w_a_next      = op_a ^ w_sign_mask;
          w_b_next      = op_b ^ w_sign_mask;
          w_idx_next    = '0;
          w_lt_next     = 1'b0;
          w_eq_next     = 1'b0;
          w_gt_next     = 1'b0;
          w_cycles_next = '0;
          w_dec_next    = 1'b0;
          w_dec_lt_next = 1'b0;
          w_dec_gt_next = 1'b0;
        end
      end

      S_RUN: begin
        busy = 1'b1;
        if ((EARLY_EXIT && (w_cur_lt || w_cur_gt)) || w_last) begin
          // With early exit this is idx+1 at the deciding digit; without it
          // we only get here on the last digit, where idx+1 == NDIG.
          w_state_next  = S_DONE;
          w_lt_next     = w_fin_lt;
          w_gt_next     = w_fin_gt;
          w_eq_next     = !(w_fin_lt || w_fin_gt);
          w_cycles_next = w_cnt;
        end else begin
          w_idx_next = r_idx + IW'(1);
          if (!r_dec && (w_cur_lt || w_cur_gt)) begin
            w_dec_next    = 1'b1;
            w_dec_lt_next = w_cur_lt;
            w_dec_gt_next = w_cur_gt;
          end
        end
      end

      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign lt     = r_lt;
  assign eq     = r_eq;
  assign gt     = r_gt;
  assign cycles = r_cycles;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// tb_serial_mag_comparator
//
// Drives two comparators (early exit on and off) from the same stimulus and
// checks results, cycle counts, latency, the start/busy/done handshake and
// reset abort. Expected values come from hand-computed vectors and from a
// behavioural compare for the random sweep.
// ---------------------------------------------------------------------------
module tb_serial_mag_comparator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode_signed = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;

  logic        busy1, done1, lt1, eq1, gt1;
  logic [2:0]  cycles1;
  logic        busy0, done0, lt0, eq0, gt0;
  logic [2:0]  cycles0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_signed(mode_signed),
    .op_a(op_a), .op_b(op_b), .busy(busy1), .done(done1),
    .lt(lt1), .eq(eq1), .gt(gt1), .cycles(cycles1)
  );

  serial_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_signed(mode_signed),
    .op_a(op_a), .op_b(op_b), .busy(busy0), .done(done0),
    .lt(lt0), .eq(eq0), .gt(gt0), .cycles(cycles0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One compare on both instances. Operands are scrambled right after the
  // accept edge to show they were registered.
  task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                         input logic elt, input logic eeq, input logic egt,
                         input int ecyc, input string tag, input bit verbose);
    int lat1, lat0, nd1, nd0;
    @(negedge clk);
    op_a = a; op_b = b; mode_signed = sgn; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = ~a; op_b = b ^ 16'h5a5a; mode_signed = ~sgn;
    lat1 = -1; lat0 = -1; nd1 = 0; nd0 = 0;
    for (int j = 0; j <= 8; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 0) begin
        check({tag, ".busy_run"}, 32'(busy1), 32'd1);
        check({tag, ".res_clear"}, 32'({lt1, eq1, gt1}), 32'd0);
      end
      if (done1) begin nd1++; if (lat1 < 0) lat1 = j; end
      if (done0) begin nd0++; if (lat0 < 0) lat0 = j; end
    end
    check({tag, ".lt_ee1"}, 32'(lt1), 32'(elt));
    check({tag, ".eq_ee1"}, 32'(eq1), 32'(eeq));
    check({tag, ".gt_ee1"}, 32'(gt1), 32'(egt));
    check({tag, ".cyc_ee1"}, 32'(cycles1), 32'(ecyc));
    check({tag, ".lat_ee1"}, 32'(lat1), 32'(ecyc));
    check({tag, ".ndone_ee1"}, 32'(nd1), 32'd1);
    check({tag, ".lt_ee0"}, 32'(lt0), 32'(elt));
    check({tag, ".eq_ee0"}, 32'(eq0), 32'(eeq));
    check({tag, ".gt_ee0"}, 32'(gt0), 32'(egt));
    check({tag, ".cyc_ee0"}, 32'(cycles0), 32'd4);
    check({tag, ".lat_ee0"}, 32'(lat0), 32'd4);
    check({tag, ".ndone_ee0"}, 32'(nd0), 32'd1);
    check({tag, ".busy_end"}, 32'({busy1, busy0}), 32'd0);
    if (verbose)
      $display("txn %s a=%04h b=%04h s=%0d -> lt/eq/gt=%0d%0d%0d cyc=%0d lat=%0d",
               tag, a, b, sgn, lt1, eq1, gt1, cycles1, lat1);
  endtask

  function automatic int first_diff(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    x = a ^ b;
    for (int k = 0; k < 4; k++)
      if (x[15-4*k -: 4] != 4'h0) return k + 1;
    return 4;
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic        lt;
    logic        eq;
    logic        gt;
    int          cyc;
  } vec_t;

  vec_t vecs[12] = '{
    '{16'h0018, 16'h0012, 1'b0, 1'b0, 1'b0, 1'b1, 4},
    '{16'h000A, 16'h000E, 1'b0, 1'b1, 1'b0, 1'b0, 4},
    '{16'h0018, 16'h0018, 1'b0, 1'b0, 1'b1, 1'b0, 4},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 4},
    '{16'hA000, 16'h1FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1},
    '{16'hA000, 16'h1FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1},
    '{16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1},
    '{16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 4},
    '{16'h7FFF, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1},
    '{16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1},
    '{16'h1234, 16'h1235, 1'b0, 1'b1, 1'b0, 1'b0, 4},
    '{16'h1204, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 3}
  };

  initial begin
    int          j, nd;
    logic [15:0] a, b, mask, rnd;
    logic        s, elt, egt;
    logic [15:0] masks[5] = '{16'h0000, 16'hF000, 16'hFF00, 16'hFFF0, 16'hFFFF};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.outs_ee1", 32'({busy1, done1, lt1, eq1, gt1, cycles1}), 32'd0);
    check("rst.outs_ee0", 32'({busy0, done0, lt0, eq0, gt0, cycles0}), 32'd0);
    rst_n = 1'b1;

    // Directed vectors.
    foreach (vecs[i])
      run_cmp(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].lt, vecs[i].eq, vecs[i].gt,
              vecs[i].cyc, $sformatf("vec%0d", i), 1'b1);

    // Handshake: start held high through RUN and the DONE cycle, operands
    // changed mid-run; the original compare must be the one reported.
    @(negedge clk);
    op_a = 16'h0018; op_b = 16'h0012; mode_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    op_a = 16'h0000; op_b = 16'hFFFF;
    j = 0;
    while (!done1 && j < 8) begin
      @(negedge clk);
      j++;
    end
    check("hs.lat", 32'(j), 32'd4);
    check("hs.gt", 32'(gt1), 32'd1);
    check("hs.cyc", 32'(cycles1), 32'd4);
    @(negedge clk);
    start = 1'b0;
    check("hs.done_width", 32'(done1), 32'd0);
    check("hs.no_reaccept", 32'({busy1, busy0}), 32'd0);
    check("hs.hold", 32'({lt1, eq1, gt1}), 32'b001);
    $display("txn handshake lat=%0d gt=%0d cyc=%0d busy=%0d", j, gt1, cycles1, busy1);

    // Reset during the second RUN cycle aborts the compare.
    @(negedge clk);
    op_a = 16'h0018; op_b = 16'h0012; mode_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid.busy", 32'({busy1, busy0}), 32'd0);
    check("rstmid.res", 32'({lt1, eq1, gt1, cycles1}), 32'd0);
    check("rstmid.res0", 32'({lt0, eq0, gt0, cycles0}), 32'd0);
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done1 || done0) nd++;
    end
    check("rstmid.no_done", 32'(nd), 32'd0);
    $display("txn reset_abort busy=%0d res=%0d%0d%0d cyc=%0d dones=%0d",
             busy1, lt1, eq1, gt1, cycles1, nd);
    run_cmp(16'h000A, 16'h000E, 1'b0, 1'b1, 1'b0, 1'b0, 4, "after_rst", 1'b1);

    // Random sweep against a behavioural compare, both modes.
    for (int i = 0; i < 3000; i++) begin
      s    = i[0];
      a    = 16'($urandom);
      rnd  = 16'($urandom);
      mask = masks[$urandom_range(0, 4)];
      b    = (a & mask) | (rnd & ~mask);
      elt  = s ? ($signed(a) < $signed(b)) : (a < b);
      egt  = s ? ($signed(a) > $signed(b)) : (a > b);
      run_cmp(a, b, s, elt, (a == b), egt, first_diff(a, b), "sweep", 1'b0);
    end
    $display("txn sweep pairs=3000");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
